patch_capture_buffer: RTL
=========================

# patch_capture_buffer

Parametrised, double-buffered pixel patch grabber for the object-tracking pipeline. It watches a raster pixel stream with CH channels of DW bits and captures a W×H window at a programmable origin from the next frame after arming. It then publishes the patch atomically on a 3-D output array for the tracker/matcher. The published patch stays stable throughout the next capture.

## Interface
- DW, 10, bits per channel sample
- CH, 3, channels per pixel (R,G,B by default)
- W, 16, patch width in pixels
- H, 16, patch height in pixels
- CW, 11, width of frame column/row coordinates

- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_pix  in  [0:CH-1][DW-1:0]  channel samples of current pixel
- i_valid  in  1  pixel beat qualifier
- i_sof  in  1  first pixel of frame; only meaningful with i_valid
- i_eol  in  1  last pixel of line; only meaningful with i_valid
- i_arm  in  1  request capture on the next frame
- i_org_x  in  CW  window left column, latched on accepted arm
- i_org_y  in  CW  window top row, latched on accepted arm
- o_buf  out  [0:CH-1][0:H-1][0:W-1][DW-1:0]  published patch, o_buf[c][r][x]
- o_busy  out  1  high in ARMED and CAPTURE
- o_done  out  1  one-cycle pulse on patch publish
- o_err  out  1  one-cycle pulse on aborted capture

## Operation
- States: IDLE, ARMED, CAPTURE.
- IDLE: when i_arm=1, latch the origin and go to ARMED. i_arm is ignored in every other state.
- ARMED: a beat with i_valid&i_sof moves the block to CAPTURE. That beat is pixel (col 0, row 0) and is itself eligible for capture.
- Position counters: col and row, CW bits each.
  - On an sof beat, the beat is (0,0).
  - After an eol beat, col=0 and row+1.
  - After any other valid beat, col+1.
  - Counters hold when i_valid=0.
- Window test uses CW+1-bit arithmetic so that org+W and org+H cannot wrap: org_x ≤ col < org_x+W and org_y ≤ row < org_y+H.
- In-window beats write to the shadow array: shadow[c][row-org_y][col-org_x] = i_pix[c]. Out-of-window beats are discarded.
- Completion: the beat at (org_x+W-1, org_y+H-1) is written. Then the whole shadow array is copied into o_buf, o_done pulses, and the state returns to IDLE.
- Abort: an sof beat arrives in CAPTURE before completion (window extends past the frame edge). o_err pulses, the state returns to IDLE, and o_buf is unchanged. The sof beat does not start a new capture.
- o_buf changes only on completion or reset. Partial patches are never visible.

## Timing
- Reset values: state IDLE, col/row 0, o_buf all 0, o_busy 0, o_done 0, o_err 0. Shadow contents need no reset.
- i_arm sampled at edge k: o_busy=1 from edge k (registered, visible after edge k).
- i_arm and i_sof in the same cycle while IDLE: the arm is accepted, and that sof is not used. Capture starts at the following sof.
- The last window beat sampled at edge k: after edge k, o_buf holds the new patch, o_done=1, and o_busy=0. At edge k+1, o_done returns to 0. Latency is one cycle.
- Abort sof sampled at edge k: o_err=1 for the cycle after edge k, and o_busy=0.
- Re-arm is accepted in the same cycle that o_done or o_err is high, because the state is already IDLE.
- Asynchronous reset mid-capture: immediate return to reset values, including o_buf=0.
- i_eol and i_sof may both be high on one beat (1-pixel-wide frame). sof takes priority for the position, then the eol rule applies for the next beat.

## Test plan
- Reset: hold i_rst_n=0 with random inputs. Required: o_buf all 0 and o_busy/o_done/o_err 0. Release, with no arm: outputs stay 0 across a full frame.
- Defaults, 20×20 frame with i_pix[0]=row*20+col, [1]=+1000, [2]=+2000 (mod 1024), origin (0,0). Required: o_done exactly one cycle after beat (15,15) is sampled, o_buf[0][r][x]=r*20+x, and o_buf[2][15][15]=(315+2000) mod 1024=267.
- Origin (4,2) on the same frame with random i_valid gaps. Required: o_buf[0][0][0]=44, o_buf[0][15][15]=359, and o_done timing unaffected apart from the gap stretch.
- Double buffering: capture frame A, then arm and stream frame B with +1 values. Required: o_buf equals A on every cycle until B's o_done, then equals B.
- Out-of-frame window: origin (10,10) on a 20×20 frame. Required: no o_done, o_err pulse one cycle after the next sof, o_buf unchanged, o_busy=0.
- Arm while busy and mid-capture reset: an i_arm pulse during CAPTURE with a new origin is ignored, and the patch uses the original origin. Asserting i_rst_n=0 during a second capture clears o_buf to 0 immediately and returns the block to IDLE.

Source files
------------

// File: rtl/patch_capture_buffer.sv
// patch_capture_buffer: double-buffered WxH pixel patch grabber.
// Captures a window from a raster stream and publishes it atomically.
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_pix/i_valid       : CH x DW pixel beat and qualifier
//   i_sof/i_eol         : frame start / line end markers (with i_valid)
//   i_arm, i_org_x/y    : arm request and window origin (latched in IDLE)
//   o_buf               : published patch o_buf[c][r][x]
//   o_busy/o_done/o_err : armed-or-capturing, publish pulse, abort pulse
module patch_capture_buffer #(
  parameter int DW = 10,
  parameter int CH = 3,
  parameter int W  = 16,
  parameter int H  = 16,
  parameter int CW = 11
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [0:CH-1][DW-1:0]                 i_pix,
  input  logic                                  i_valid,
  input  logic                                  i_sof,
  input  logic                                  i_eol,
  input  logic                                  i_arm,
  input  logic [CW-1:0]                         i_org_x,
  input  logic [CW-1:0]                         i_org_y,
  output logic [0:CH-1][0:H-1][0:W-1][DW-1:0]   o_buf,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic                                  o_err
);

  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int YW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPT
  } state_t;

  typedef logic [0:CH-1][0:H-1][0:W-1][DW-1:0] patch_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] org_x_q, org_x_d;
  logic [CW-1:0] org_y_q, org_y_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  patch_t        shadow_q, shadow_d;
  patch_t        buf_q, buf_d;

  logic [CW-1:0] pcol, prow;
  logic [CW:0]   pcol_w, prow_w;
  logic [CW:0]   x_lo, x_hi, y_lo, y_hi;
  logic [CW-1:0] rel_x, rel_y;
  logic          in_win, last_px;
  logic          cap_beat, wr_en;
  logic          complete, abort;

  // Position of the current beat; sof forces (0,0).
  always_comb begin
    pcol  = i_sof ? '0 : col_q;
    prow  = i_sof ? '0 : row_q;
    col_d = col_q;
    row_d = row_q;
    if (i_valid) begin
      if (i_eol) begin
        col_d = '0;
        row_d = prow + 1'b1;
      end else begin
        col_d = pcol + 1'b1;
        row_d = prow;
      end
    end
  end

  // Window bounds in CW+1 bits so org+W / org+H never wrap.
  always_comb begin
    pcol_w  = {1'b0, pcol};
    prow_w  = {1'b0, prow};
    x_lo    = {1'b0, org_x_q};
    y_lo    = {1'b0, org_y_q};
    x_hi    = x_lo + (CW+1)'(W);
    y_hi    = y_lo + (CW+1)'(H);
    in_win  = (pcol_w >= x_lo) && (pcol_w < x_hi) &&
              (prow_w >= y_lo) && (prow_w < y_hi);
    last_px = (pcol_w == x_hi - 1'b1) &&
              (prow_w == y_hi - 1'b1);
    rel_x   = pcol - org_x_q;
    rel_y   = prow - org_y_q;
  end

  // The sof beat that leaves ARMED is itself pixel (0,0) of the capture.
  always_comb begin
    cap_beat = i_valid &&
               (((state_q == S_ARMED) && i_sof) ||
                ((state_q == S_CAPT) && !i_sof));
    wr_en    = cap_beat && in_win;
    complete = wr_en && last_px;
    abort    = i_valid && i_sof && (state_q == S_CAPT);
  end

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      for (int c = 0; c < CH; c++) begin
        shadow_d[c][rel_y[YW-1:0]][rel_x[XW-1:0]] = i_pix[c];
      end
    end
  end

  // Publish includes the final beat being written this cycle.
  always_comb begin
    buf_d = complete ? shadow_d : buf_q;
  end

  always_comb begin
    org_x_d = org_x_q;
    org_y_d = org_y_q;
    if ((state_q == S_IDLE) && i_arm) begin
      org_x_d = i_org_x;
      org_y_d = i_org_y;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (i_valid && i_sof) begin
          state_d = complete ? S_IDLE : S_CAPT;
        end
      end
      S_CAPT: begin
        if (abort || complete) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy = (state_q != S_IDLE);
    done_d = complete;
    err_d  = abort;
  end

  // FSM: state and control registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      org_x_q <= '0;
      org_y_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      org_x_q <= org_x_d;
      org_y_q <= org_y_d;
      done_q  <= done_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    shadow_q <= shadow_d;
  end

  assign o_buf  = buf_q;
  assign o_done = done_q;
  assign o_err  = err_q;

endmodule
